// File: rtl/t05_cb_synthesis_param_if.sv
// t05_cb_synthesis_param_if: node-fetch request/ack bus plus codeword valid/ready stream.
interface t05_cb_synthesis_param_if #(
    parameter int SYM_W     = 8,
    parameter int IDX_W     = 7,
    parameter int MAX_DEPTH = 32,
    parameter int LEN_W     = $clog2(MAX_DEPTH + 1)
);
    logic                 mem_req;
    logic [IDX_W-1:0]     mem_addr;
    logic                 mem_ack;
    logic [2*SYM_W+1:0]   mem_node;
    logic                 cw_valid;
    logic                 cw_ready;
    logic [SYM_W-1:0]     cw_sym;
    logic [MAX_DEPTH-1:0] cw_code;
    logic [LEN_W-1:0]     cw_len;

    modport master (
        output mem_req, mem_addr, cw_valid, cw_sym, cw_code, cw_len,
        input  mem_ack, mem_node, cw_ready
    );
    modport slave (
        input  mem_req, mem_addr, cw_valid, cw_sym, cw_code, cw_len,
        output mem_ack, mem_node, cw_ready
    );
endinterface

// File: rtl/t05_cb_synthesis_param.sv
// t05_cb_synthesis_param: depth-first walk of a binary code tree in node memory, emitting one codeword per leaf.
module t05_cb_synthesis_param #(
    parameter int SYM_W     = 8,
    parameter int IDX_W     = 7,
    parameter int MAX_DEPTH = 32,
    parameter int CNT_W     = 9,
    parameter int LEN_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [IDX_W-1:0]       i_root_index,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic [CNT_W-1:0]       o_cw_count,
    t05_cb_synthesis_param_if.master bus
);
    localparam int D_W = $clog2(MAX_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_VISIT, S_EMIT, S_POP, S_DONE} state_t;

    state_t               r_state, w_next;
    logic [IDX_W-1:0]     r_cur;
    logic                 r_side;
    logic [D_W-1:0]       r_depth;
    logic [MAX_DEPTH-1:0] r_path;
    logic [2*SYM_W+1:0]   r_node;
    logic [IDX_W-1:0]     r_stk_addr [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] r_stk_side;
    logic [SYM_W-1:0]     r_sym;
    logic [MAX_DEPTH-1:0] r_code;
    logic [LEN_W-1:0]     r_len;
    logic [CNT_W-1:0]     r_count;
    logic                 r_err;

    logic                 w_flag, w_null, w_deep;
    logic [SYM_W-1:0]     w_val;
    logic [D_W-1:0]       w_top;
    logic [MAX_DEPTH-1:0] w_path_set;

    // Child selected by the current side; all-ones right child marks NULL.
    assign w_flag     = r_side ? r_node[SYM_W] : r_node[2*SYM_W+1];
    assign w_val      = r_side ? r_node[SYM_W-1:0] : r_node[2*SYM_W:SYM_W+1];
    assign w_null     = r_side & w_flag & (&w_val);
    assign w_deep     = r_depth >= D_W'(MAX_DEPTH - 1);
    assign w_top      = r_depth - D_W'(1);
    assign w_path_set = r_path | (MAX_DEPTH'(r_side) << r_depth);

    assign bus.mem_req  = r_state == S_FETCH;
    assign bus.mem_addr = bus.mem_req ? r_cur : '0;
    assign bus.cw_valid = r_state == S_EMIT;
    assign bus.cw_sym   = r_sym;
    assign bus.cw_code  = r_code;
    assign bus.cw_len   = r_len;
    assign o_busy       = r_state != S_IDLE;
    assign o_done       = r_state == S_DONE;
    assign o_err        = r_err;
    assign o_cw_count   = r_count;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_start ? S_FETCH : S_IDLE;
            S_FETCH: w_next = bus.mem_ack ? S_VISIT : S_FETCH;
            S_VISIT: w_next = w_null ? S_POP : !w_flag ? S_EMIT : w_deep ? S_DONE : S_FETCH;
            S_EMIT:  w_next = !bus.cw_ready ? S_EMIT : r_side ? S_POP : S_VISIT;
            S_POP:   w_next = r_depth == '0 ? S_DONE : r_stk_side[w_top] ? S_POP : S_FETCH;
            default: w_next = S_IDLE;
        endcase
        if (i_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur      <= '0;
            r_side     <= 1'b0;
            r_depth    <= '0;
            r_path     <= '0;
            r_node     <= '0;
            r_stk_side <= '0;
            r_sym      <= '0;
            r_code     <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < MAX_DEPTH; i++) r_stk_addr[i] <= '0;
        end else if (!i_abort) begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_cur   <= i_root_index;
                    r_depth <= '0;
                    r_side  <= 1'b0;
                    r_path  <= '0;
                    r_count <= '0;
                    r_err   <= 1'b0;
                end
                S_FETCH: if (bus.mem_ack) r_node <= bus.mem_node;
                S_VISIT: if (!w_null) begin
                    if (!w_flag) begin
                        r_path <= w_path_set;
                        r_sym  <= w_val;
                        r_code <= w_path_set;
                        r_len  <= LEN_W'(r_depth) + LEN_W'(1);
                    end else if (w_deep) begin
                        r_err <= 1'b1;
                    end else begin
                        r_stk_addr[r_depth] <= r_cur;
                        r_stk_side[r_depth] <= r_side;
                        r_path  <= w_path_set;
                        r_depth <= r_depth + D_W'(1);
                        r_cur   <= w_val[IDX_W-1:0];
                        r_side  <= 1'b0;
                    end
                end
                S_EMIT: if (bus.cw_ready) begin
                    if (~&r_count) r_count <= r_count + CNT_W'(1);
                    r_path[r_depth] <= 1'b0;
                    r_side <= 1'b1;
                end
                // A popped left branch resumes on its right side; a popped right branch keeps unwinding.
                S_POP: if (r_depth != '0) begin
                    r_depth       <= w_top;
                    r_cur         <= r_stk_addr[w_top];
                    r_path[w_top] <= !r_stk_side[w_top];
                    if (!r_stk_side[w_top]) r_side <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_t05_cb_synthesis_param.sv
// tb_t05_cb_synthesis_param: directed scenarios against a small node-memory model and a MAX_DEPTH=4 instance.
module tb_t05_cb_synthesis_param;
    logic       clk = 0;
    logic       rst_n = 1;
    logic       start = 0, start4 = 0, abort = 0;
    logic [6:0] root = '0;
    logic       busy, done, err, busy4, done4, err4;
    logic [8:0] cnt, cnt4;
    int         n_checks = 0, n_pass = 0;

    logic [17:0] mem  [128];
    logic [17:0] mem4 [128];

    always #5 clk = ~clk;

    t05_cb_synthesis_param_if bus ();
    t05_cb_synthesis_param_if #(.MAX_DEPTH(4)) bus4 ();

    t05_cb_synthesis_param dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_root_index(root),
        .o_busy(busy), .o_done(done), .o_err(err), .o_cw_count(cnt), .bus(bus)
    );
    t05_cb_synthesis_param #(.MAX_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_start(start4), .i_abort(abort), .i_root_index(root),
        .o_busy(busy4), .o_done(done4), .o_err(err4), .o_cw_count(cnt4), .bus(bus4)
    );

    assign bus.mem_ack   = bus.mem_req;
    assign bus.mem_node  = mem[bus.mem_addr];
    assign bus4.mem_ack  = bus4.mem_req;
    assign bus4.mem_node = mem4[bus4.mem_addr];

    function automatic logic [8:0] lf(input int s);
        return {1'b0, 8'(s)};
    endfunction
    function automatic logic [8:0] nd(input int a);
        return {1'b1, 8'(a)};
    endfunction
    localparam logic [8:0] NUL = 9'h1FF;

    task automatic start_run(input int r);
        @(negedge clk);
        root = 7'(r);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic get_cw(output logic [7:0] s, output logic [31:0] c, output logic [5:0] l, output bit ok);
        ok = 0; s = '0; c = '0; l = '0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.cw_valid === 1'b1) begin
                s = bus.cw_sym; c = bus.cw_code; l = bus.cw_len; ok = 1;
                bus.cw_ready = 1;
                @(negedge clk);
                bus.cw_ready = 0;
            end else @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (done === 1'b1) seen = 1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 128; i++) begin mem[i] = '0; mem4[i] = '0; end
        bus.cw_ready = 0;
        #2 rst_n = 0;
        #1;
        n_checks++; if (busy !== 0 || done !== 0 || err !== 0) $display("FAIL reset_status busy=%b done=%b err=%b exp 000", busy, done, err); else n_pass++;
        n_checks++; if (cnt !== 0) $display("FAIL reset_count got %0d exp 0", cnt); else n_pass++;
        n_checks++; if (bus.mem_req !== 0 || bus.mem_addr !== 0 || bus.cw_valid !== 0) $display("FAIL reset_bus req=%b addr=%0d valid=%b exp 0", bus.mem_req, bus.mem_addr, bus.cw_valid); else n_pass++;
        n_checks++; if (bus.cw_sym !== 0 || bus.cw_code !== 0 || bus.cw_len !== 0) $display("FAIL reset_cw sym=%0d code=%0h len=%0d exp 0", bus.cw_sym, bus.cw_code, bus.cw_len); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 0 || bus.mem_req !== 0) $display("FAIL idle_after_reset busy=%b req=%b exp 0", busy, bus.mem_req); else n_pass++;
    endtask

    task automatic test_single_leaf;
        logic [7:0] s; logic [31:0] c; logic [5:0] l; bit ok, seen;
        mem[0] = {lf(67), NUL};
        start_run(0);
        n_checks++; if (bus.mem_req !== 1 || bus.mem_addr !== 0 || busy !== 1) $display("FAIL single_fetch req=%b addr=%0d busy=%b exp 1 0 1", bus.mem_req, bus.mem_addr, busy); else n_pass++;
        get_cw(s, c, l, ok);
        n_checks++; if (!ok || s !== 67 || c !== 0 || l !== 1) $display("FAIL single_cw ok=%b sym=%0d code=%0h len=%0d exp 67 0 1", ok, s, c, l); else n_pass++;
        wait_done(seen);
        n_checks++; if (!seen) $display("FAIL single_done got no pulse exp pulse"); else n_pass++;
        n_checks++; if (done !== 0 || busy !== 0) $display("FAIL single_done_width done=%b busy=%b exp 0 0", done, busy); else n_pass++;
        n_checks++; if (cnt !== 1 || err !== 0) $display("FAIL single_count cnt=%0d err=%b exp 1 0", cnt, err); else n_pass++;
    endtask

    task automatic test_three_symbols;
        logic [7:0] s; logic [31:0] c; logic [5:0] l; bit ok, seen;
        int es[3], ec[3], el[3];
        es = '{65, 67, 66}; ec = '{0, 1, 3}; el = '{1, 2, 2};
        mem[0] = {lf(67), lf(66)};
        mem[1] = {lf(65), nd(0)};
        start_run(1);
        for (int k = 0; k < 3; k++) begin
            get_cw(s, c, l, ok);
            n_checks++; if (!ok || s !== es[k] || c !== ec[k] || l !== el[k]) $display("FAIL three_cw%0d ok=%b sym=%0d code=%0h len=%0d exp %0d %0h %0d", k, ok, s, c, l, es[k], ec[k], el[k]); else n_pass++;
        end
        wait_done(seen);
        n_checks++; if (!seen || cnt !== 3) $display("FAIL three_done seen=%b cnt=%0d exp 1 3", seen, cnt); else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [7:0] s; logic [31:0] c; logic [5:0] l; bit ok, seen, hit;
        start_run(1);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) if (bus.cw_valid === 1'b1) hit = 1; else @(negedge clk);
        n_checks++; if (!hit) $display("FAIL bp_first_valid got none exp cw_valid"); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            root = 7'd0;
            n_checks++;
            if (bus.cw_valid !== 1 || bus.cw_sym !== 65 || bus.cw_code !== 0 || bus.cw_len !== 1 || bus.mem_req !== 0 || cnt !== 0)
                $display("FAIL bp_hold%0d valid=%b sym=%0d code=%0h len=%0d req=%b cnt=%0d exp 1 65 0 1 0 0", i, bus.cw_valid, bus.cw_sym, bus.cw_code, bus.cw_len, bus.mem_req, cnt);
            else n_pass++;
            @(negedge clk);
            start = 0;
        end
        get_cw(s, c, l, ok);
        n_checks++; if (!ok || s !== 65 || cnt !== 1) $display("FAIL bp_release ok=%b sym=%0d cnt=%0d exp 65 1", ok, s, cnt); else n_pass++;
        get_cw(s, c, l, ok);
        n_checks++; if (!ok || s !== 67 || c !== 1 || l !== 2) $display("FAIL bp_cw2 sym=%0d code=%0h len=%0d exp 67 1 2", s, c, l); else n_pass++;
        get_cw(s, c, l, ok);
        n_checks++; if (!ok || s !== 66 || c !== 3 || l !== 2) $display("FAIL bp_cw3 sym=%0d code=%0h len=%0d exp 66 3 2", s, c, l); else n_pass++;
        wait_done(seen);
        n_checks++; if (!seen || cnt !== 3) $display("FAIL bp_done seen=%b cnt=%0d exp 1 3", seen, cnt); else n_pass++;
    endtask

    task automatic test_overflow;
        bit seen, saw_valid;
        logic e;
        for (int k = 0; k < 5; k++) mem4[k] = {nd(k + 1), NUL};
        mem4[5] = {lf(1), NUL};
        @(negedge clk);
        root = 7'd0;
        start4 = 1;
        @(negedge clk);
        start4 = 0;
        seen = 0; saw_valid = 0; e = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus4.cw_valid === 1'b1) saw_valid = 1;
            if (done4 === 1'b1) begin seen = 1; e = err4; end
            @(negedge clk);
        end
        n_checks++; if (!seen || e !== 1) $display("FAIL ovf_done seen=%b err=%b exp 1 1", seen, e); else n_pass++;
        n_checks++; if (saw_valid || cnt4 !== 0) $display("FAIL ovf_no_cw valid_seen=%b cnt=%0d exp 0 0", saw_valid, cnt4); else n_pass++;
        n_checks++; if (err4 !== 1 || busy4 !== 0) $display("FAIL ovf_sticky err=%b busy=%b exp 1 0", err4, busy4); else n_pass++;
    endtask

    task automatic test_mid_reset;
        logic [7:0] s; logic [31:0] c; logic [5:0] l; bit ok, seen, hit;
        int es[3], ec[3], el[3];
        es = '{65, 67, 66}; ec = '{0, 1, 3}; el = '{1, 2, 2};
        start_run(1);
        get_cw(s, c, l, ok);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) if (bus.mem_req === 1'b1) hit = 1; else @(negedge clk);
        n_checks++; if (!hit || cnt !== 1) $display("FAIL mrst_pre req_seen=%b cnt=%0d exp 1 1", hit, cnt); else n_pass++;
        #2 rst_n = 0;
        #1;
        n_checks++; if (bus.mem_req !== 0 || bus.mem_addr !== 0 || busy !== 0 || done !== 0) $display("FAIL mrst_async req=%b addr=%0d busy=%b done=%b exp 0", bus.mem_req, bus.mem_addr, busy, done); else n_pass++;
        n_checks++; if (cnt !== 0 || err !== 0 || bus.cw_sym !== 0 || bus.cw_len !== 0) $display("FAIL mrst_clear cnt=%0d err=%b sym=%0d len=%0d exp 0", cnt, err, bus.cw_sym, bus.cw_len); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        start_run(1);
        for (int k = 0; k < 3; k++) begin
            get_cw(s, c, l, ok);
            n_checks++; if (!ok || s !== es[k] || c !== ec[k] || l !== el[k]) $display("FAIL mrst_cw%0d ok=%b sym=%0d code=%0h len=%0d exp %0d %0h %0d", k, ok, s, c, l, es[k], ec[k], el[k]); else n_pass++;
        end
        wait_done(seen);
        n_checks++; if (!seen || cnt !== 3) $display("FAIL mrst_done seen=%b cnt=%0d exp 1 3", seen, cnt); else n_pass++;
    endtask

    task automatic test_abort;
        logic [7:0] s; logic [31:0] c; logic [5:0] l; bit ok, seen, hit;
        start_run(1);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) if (bus.cw_valid === 1'b1) hit = 1; else @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        n_checks++; if (!hit || bus.cw_valid !== 0 || busy !== 0 || done !== 0) $display("FAIL abort_idle valid_seen=%b valid=%b busy=%b done=%b exp 1 0 0 0", hit, bus.cw_valid, busy, done); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 0 || busy !== 0 || cnt !== 0 || err !== 0) $display("FAIL abort_quiet done=%b busy=%b cnt=%0d err=%b exp 0", done, busy, cnt, err); else n_pass++;
        start_run(1);
        for (int k = 0; k < 3; k++) get_cw(s, c, l, ok);
        n_checks++; if (!ok || s !== 66) $display("FAIL abort_restart_last ok=%b sym=%0d exp 66", ok, s); else n_pass++;
        wait_done(seen);
        n_checks++; if (!seen || cnt !== 3) $display("FAIL abort_restart_done seen=%b cnt=%0d exp 1 3", seen, cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_leaf();
        test_three_symbols();
        test_backpressure();
        test_overflow();
        test_mid_reset();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
